// File: rtl/fetch_vaddr_fifo_if.sv
// Handshake bundle between the fetch-address generator and the IMMU / back end.
// master = address generator side, slave = consumer/redirect side.
interface fetch_vaddr_fifo_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          redirect_valid;
  logic [63:0]   redirect_pc;
  logic          fetch_hold;
  logic          mmu_fifo_valid;
  logic          mmu_fifo_ready;
  logic [63:0]   vaddr;
  logic [CW-1:0] fifo_count;
  logic [63:0]   perf_full_cycles;

  modport master (
    input  redirect_valid, redirect_pc, fetch_hold, mmu_fifo_ready,
    output mmu_fifo_valid, vaddr, fifo_count, perf_full_cycles
  );

  modport slave (
    output redirect_valid, redirect_pc, fetch_hold, mmu_fifo_ready,
    input  mmu_fifo_valid, vaddr, fifo_count, perf_full_cycles
  );
endinterface

// File: rtl/fetch_vaddr_fifo.sv
// Sequential fetch-address generator with a DEPTH-entry queue toward the IMMU.
// Optional full-stall counter enabled by defining FETCH_FIFO_PERF_EN.
module fetch_vaddr_fifo #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input logic              clk,
  input logic              rst,
  fetch_vaddr_fifo_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   entry [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [63:0]   next_pc;
  logic          pop;
  logic          push;
  logic          full;

  function automatic logic [63:0] step_pc(input logic [63:0] pc);
    return (pc & ~64'h0000_0000_0000_0007) + 64'h0000_0000_0000_0008;
  endfunction

  // Handshake decode; a redirect voids any pop and suppresses the normal push.
  always_comb begin
    full = (count == CW'(DEPTH));
    pop  = (count != {CW{1'b0}}) & ~bus.redirect_valid & bus.mmu_fifo_ready;
    push = ~bus.redirect_valid & ~bus.fetch_hold & (~full | pop);
  end

  // Pointer, occupancy and next-address state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= {AW{1'b0}};
      wr_ptr  <= {AW{1'b0}};
      count   <= {CW{1'b0}};
      next_pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      rd_ptr  <= {AW{1'b0}};
      wr_ptr  <= AW'(1);
      count   <= CW'(1);
      next_pc <= step_pc(bus.redirect_pc);
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        next_pc <= step_pc(next_pc);
      end
      if (push & ~pop) begin
        count <= count + CW'(1);
      end else if (pop & ~push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Entry storage is data-only; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (!rst && bus.redirect_valid) begin
      entry[{AW{1'b0}}] <= bus.redirect_pc;
    end else if (!rst && push) begin
      entry[wr_ptr] <= next_pc;
    end
  end

  assign bus.mmu_fifo_valid = (count != {CW{1'b0}}) & ~bus.redirect_valid;
  assign bus.vaddr          = rst ? 64'h0000_0000_0000_0000 : entry[rd_ptr];
  assign bus.fifo_count     = count;

`ifdef FETCH_FIFO_PERF_EN
  logic [63:0] perf_cnt;

  // Counts cycles where the queue is full and nothing drains it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt <= 64'h0000_0000_0000_0000;
    end else if (full & ~pop & ~bus.redirect_valid) begin
      perf_cnt <= perf_cnt + 64'h0000_0000_0000_0001;
    end else begin
      perf_cnt <= perf_cnt;
    end
  end

  assign bus.perf_full_cycles = perf_cnt;
`else
  assign bus.perf_full_cycles = 64'h0000_0000_0000_0000;
`endif
endmodule

// File: tb/tb_fetch_vaddr_fifo.sv
// Self-checking bench: directed vector table, hand sequences, and random traffic
// compared against a queue-based reference model.
module tb_fetch_vaddr_fifo;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_vaddr_fifo_if #(.DEPTH(DEPTH)) bus ();

  fetch_vaddr_fifo #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        redir;
    logic [63:0] rpc;
    logic        hold;
    logic        ready;
    logic        exp_valid;
    logic [63:0] exp_vaddr;
    logic [2:0]  exp_count;
  } vec_t;

  vec_t tbl [15];

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] mq [$];
  logic [63:0] m_npc;
  logic [63:0] m_perf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_perf();
`ifdef FETCH_FIFO_PERF_EN
    return m_perf;
`else
    return 64'h0;
`endif
  endfunction

  // Called at a negedge: apply inputs and compare outputs against the model.
  task automatic drive_check(input logic redir, input logic [63:0] rpc, input logic hold, input logic ready);
    logic mv;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.fetch_hold     = hold;
    bus.mmu_fifo_ready = ready;
    #1;
    mv = (mq.size() != 0) && !redir;
    chk("model_valid", {63'h0, bus.mmu_fifo_valid}, {63'h0, mv});
    if (mv) chk("model_vaddr", bus.vaddr, mq[0]);
    chk("model_count", {61'h0, bus.fifo_count}, 64'(mq.size()));
    chk("model_perf", bus.perf_full_cycles, exp_perf());
  endtask

  // Clock edge, then model update from the applied inputs, ending at the next negedge.
  task automatic advance();
    logic pop;
    @(posedge clk);
    if (bus.redirect_valid) begin
      mq.delete();
      mq.push_back(bus.redirect_pc);
      m_npc = {bus.redirect_pc[63:3], 3'b000} + 64'd8;
    end else begin
      pop = (mq.size() != 0) && bus.mmu_fifo_ready;
      if (mq.size() == DEPTH && !pop) m_perf = m_perf + 64'd1;
      if (pop) void'(mq.pop_front());
      if (!bus.fetch_hold && (mq.size() < DEPTH)) begin
        mq.push_back(m_npc);
        m_npc = {m_npc[63:3], 3'b000} + 64'd8;
      end
    end
    @(negedge clk);
  endtask

  task automatic step(input logic redir, input logic [63:0] rpc, input logic hold, input logic ready);
    drive_check(redir, rpc, hold, ready);
    advance();
  endtask

  task automatic model_reset();
    mq.delete();
    m_npc  = RESET_PC;
    m_perf = 64'h0;
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    bus.fetch_hold     = 1'b0;
    bus.mmu_fifo_ready = 1'b0;

    for (int i = 0; i < 15; i++) begin
      tbl[i] = '{1'b0, 64'h0, 1'b0, (i >= 10), 1'b1, RESET_PC, 3'd4};
    end
    tbl[0].exp_valid = 1'b0; tbl[0].exp_count = 3'd0;
    tbl[1].exp_count = 3'd1;
    tbl[2].exp_count = 3'd2;
    tbl[3].exp_count = 3'd3;
    tbl[11].exp_vaddr = 64'h0000_0000_8000_0008;
    tbl[12].exp_vaddr = 64'h0000_0000_8000_0010;
    tbl[13].exp_vaddr = 64'h0000_0000_8000_0018;
    tbl[14].exp_vaddr = 64'h0000_0000_8000_0020;

    // Reset state.
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_valid", {63'h0, bus.mmu_fifo_valid}, 64'h0);
    chk("rst_vaddr", bus.vaddr, 64'h0);
    chk("rst_count", {61'h0, bus.fifo_count}, 64'h0);
    chk("rst_perf", bus.perf_full_cycles, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed table: stall for 10 cycles, then drain in order.
    for (int i = 0; i < 15; i++) begin
      drive_check(tbl[i].redir, tbl[i].rpc, tbl[i].hold, tbl[i].ready);
      chk($sformatf("tbl%0d_valid", i), {63'h0, bus.mmu_fifo_valid}, {63'h0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d_vaddr", i), bus.vaddr, tbl[i].exp_vaddr);
      chk($sformatf("tbl%0d_count", i), {61'h0, bus.fifo_count}, {61'h0, tbl[i].exp_count});
`ifdef FETCH_FIFO_PERF_EN
      if (i == 14) chk("perf_full6", bus.perf_full_cycles, 64'd6);
`else
      if (i == 14) chk("perf_tied0", bus.perf_full_cycles, 64'd0);
`endif
      advance();
    end

    // Redirect while holding 3 entries.
    step(1'b0, 64'h0, 1'b1, 1'b1);
    drive_check(1'b1, 64'h0000_0000_8000_1234, 1'b0, 1'b1);
    chk("redir_valid0", {63'h0, bus.mmu_fifo_valid}, 64'h0);
    advance();
    drive_check(1'b0, 64'h0, 1'b0, 1'b1);
    chk("redir_vaddr", bus.vaddr, 64'h0000_0000_8000_1234);
    chk("redir_count1", {61'h0, bus.fifo_count}, 64'd1);
    advance();
    drive_check(1'b0, 64'h0, 1'b0, 1'b1);
    chk("redir_seq1", bus.vaddr, 64'h0000_0000_8000_1238);
    advance();
    drive_check(1'b0, 64'h0, 1'b0, 1'b1);
    chk("redir_seq2", bus.vaddr, 64'h0000_0000_8000_1240);
    advance();

    // Address wrap at the top of the 64-bit space.
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b1);
    drive_check(1'b0, 64'h0, 1'b0, 1'b1);
    chk("wrap_fff8", bus.vaddr, 64'hFFFF_FFFF_FFFF_FFF8);
    advance();
    drive_check(1'b0, 64'h0, 1'b0, 1'b1);
    chk("wrap_0", bus.vaddr, 64'h0);
    advance();
    drive_check(1'b0, 64'h0, 1'b0, 1'b1);
    chk("wrap_8", bus.vaddr, 64'h8);
    advance();

    // Hold with a full FIFO: drain, drop valid, then resume without skip.
    step(1'b1, 64'h0000_0000_0000_1000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 64'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive_check(1'b0, 64'h0, 1'b1, 1'b1);
      if (i == 0) chk("hold_full", {61'h0, bus.fifo_count}, 64'd4);
      chk($sformatf("hold_pop%0d", i), bus.vaddr, 64'h1000 + 64'(8 * i));
      advance();
    end
    drive_check(1'b0, 64'h0, 1'b1, 1'b1);
    chk("hold_empty", {63'h0, bus.mmu_fifo_valid}, 64'h0);
    advance();
    step(1'b0, 64'h0, 1'b0, 1'b1);
    drive_check(1'b0, 64'h0, 1'b0, 1'b1);
    chk("hold_resume", bus.vaddr, 64'h0000_0000_0000_1020);
    advance();

    // Mid-stream reset clears outputs immediately and restarts at RESET_PC.
    for (int i = 0; i < 3; i++) step(1'b0, 64'h0, 1'b0, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    chk("mrst_valid", {63'h0, bus.mmu_fifo_valid}, 64'h0);
    chk("mrst_vaddr", bus.vaddr, 64'h0);
    chk("mrst_count", {61'h0, bus.fifo_count}, 64'h0);
    chk("mrst_perf", bus.perf_full_cycles, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 64'h0, 1'b0, 1'b1);
    drive_check(1'b0, 64'h0, 1'b0, 1'b1);
    chk("mrst_restart", bus.vaddr, RESET_PC);
    advance();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic [63:0] pc;
      r  = ($urandom_range(15) == 0);
      pc = ($urandom_range(3) == 0) ? (64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(31)))
                                    : {$urandom, $urandom};
      step(r, pc, ($urandom_range(3) == 0), $urandom_range(1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_vaddr_fifo.md
# fetch_vaddr_fifo

Fetch-address generator and buffer feeding the instruction MMU. Produces a stream of 8-byte-aligned virtual fetch addresses starting at the reset vector or at a redirect target. It queues them in a DEPTH-entry FIFO and hands them to the IMMU over its `mmu_fifo_valid`/`mmu_fifo_ready`/`vaddr` handshake. Redirects from the back end discard all queued addresses and restart the stream in the same cycle.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `RESET_PC`, 64'h8000_0000, first fetch address after reset.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `redirect_valid` in 1: flush the FIFO and restart the stream at `redirect_pc`.
- `redirect_pc` in 64: restart address; may be unaligned.
- `fetch_hold` in 1: suppress new pushes, e.g. for WFI or fence.i drain; pops continue.
- `mmu_fifo_valid` out 1: head entry valid.
- `mmu_fifo_ready` in 1: IMMU accepts the head.
- `vaddr` out 64: head entry address.
- `fifo_count` out clog2(DEPTH)+1: occupancy.
- `perf_full_cycles` out 64: full-stall counter. See Configuration.

## Operation
- State:
  - `next_pc` (64).
  - Entry array.
  - `rd_ptr` and `wr_ptr` (clog2(DEPTH) bits each, wrap modulo DEPTH).
  - `count` (0..DEPTH).
- Pop: occurs when `mmu_fifo_valid & mmu_fifo_ready`. Advances `rd_ptr`.
- Push: occurs when all of the following hold:
  - `~redirect_valid` and `~fetch_hold`;
  - `count < DEPTH`, or `count == DEPTH` with a pop in the same cycle.
- On push:
  - Write `next_pc` at `wr_ptr` and advance `wr_ptr`.
  - Update `next_pc` to `(next_pc & ~64'h7) + 8`. Arithmetic is modulo 2^64, so 64'hFFFF_FFFF_FFFF_FFF8 steps to 0.
- Simultaneous push and pop leave `count` unchanged.
- Push into an empty FIFO is not bypassed; `mmu_fifo_valid` rises the next cycle.
- Redirect has highest priority and takes effect in the same cycle:
  - All entries are discarded.
  - `entry[0] = redirect_pc` exactly, unaligned allowed.
  - `rd_ptr = 0`, `wr_ptr = 1`, `count = 1`.
  - `next_pc = (redirect_pc & ~7) + 8`.
  - `fetch_hold` is ignored for this one write.
- `mmu_fifo_valid = (count != 0) & ~redirect_valid`.
  - Any handshake in a redirect cycle is void.
  - The IMMU must not consume the address in that cycle.
- `vaddr = entry[rd_ptr]`. Its value is don't-care when `mmu_fifo_valid` is 0.
- `fifo_count = count`.

## Timing
- Reset values:
  - `count = 0`, pointers 0, `next_pc = RESET_PC`.
  - `mmu_fifo_valid = 0`, `fifo_count = 0`, `perf_full_cycles = 0`.
  - `vaddr` is entry-array data and not reset, but is forced to 0 while `rst` is high.
- After reset deassert:
  - Cycle 0: pushes `RESET_PC`.
  - Cycle 1: `mmu_fifo_valid = 1`, `vaddr = RESET_PC`.
- Redirect in cycle N: the target is presented with `mmu_fifo_valid = 1` in cycle N+1.
- Throughput: one address per cycle sustained when `mmu_fifo_ready` is held high.
- Full FIFO with no pop: no push, and `next_pc` holds.
- Reset asserted mid-stream clears all state asynchronously. No partially written entry survives.
- `fetch_hold` asserted with a full FIFO: pops drain the FIFO to empty, then `mmu_fifo_valid` drops. Deasserting the hold resumes from the held `next_pc`.

## Configuration
- `FETCH_FIFO_PERF_EN`:
  - Defined: `perf_full_cycles` increments by 1 each cycle with `count == DEPTH`, no pop, and no redirect. It wraps modulo 2^64 and is cleared only by reset.
  - Undefined: no counter register; `perf_full_cycles` is tied to 0.

## Test plan
- Reset release with `mmu_fifo_ready = 1`: `vaddr` sequence 8000_0000, 8000_0008, 8000_0010…, valid from cycle 1, one per cycle.
- `mmu_fifo_ready = 0` for 10 cycles: `fifo_count` climbs 1..4 and holds. Then raise ready: addresses 8000_0000..8000_0018 delivered in order with no gap, followed by 8000_0020. With `FETCH_FIFO_PERF_EN`, `perf_full_cycles` equals the full-stall cycles (6).
- Redirect to 8000_1234 while holding 3 entries:
  - `mmu_fifo_valid` is 0 in the redirect cycle.
  - Next cycle: `vaddr = 8000_1234`, `fifo_count = 1`.
  - Then 8000_1238, 8000_1240.
- Redirect to FFFF_FFFF_FFFF_FFF8: sequence …FFF8, 0000_0000_0000_0000, 0000_0000_0000_0008.
- `fetch_hold = 1` with a full FIFO and ready high: 4 pops, then valid low. Release the hold: the next address continues the sequence with no skip or duplicate.
- Assert `rst` mid-stream with entries queued: outputs are 0 immediately. After release, the stream restarts at 8000_0000.
